// File: rtl/ex_mem_elastic_stage.sv
// EX->MEM pipeline register with a valid/ready handshake and a two-entry skid buffer (main + skid).
// Define EX_MEM_STATS_EN to add the saturating stall_cnt/bubble_cnt counters.
module ex_mem_elastic_stage #(
    parameter int DATA_W  = 16,
    parameter int WADDR_W = 4,
    parameter int PC_W    = 16,
    parameter int CTRL_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [DATA_W-1:0]  rdata2_in,
    input  logic [WADDR_W-1:0] waddr_in,
    input  logic [PC_W-1:0]    npc_in,
    input  logic [CTRL_W-1:0]  ctrl_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_result_out,
    output logic [DATA_W-1:0]  rdata2_out,
    output logic [WADDR_W-1:0] waddr_out,
    output logic [PC_W-1:0]    npc_out,
    output logic [CTRL_W-1:0]  ctrl_out
`ifdef EX_MEM_STATS_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        bubble_cnt
`endif
);

    localparam int PAY_W = CTRL_W + PC_W + WADDR_W + 2 * DATA_W;

    logic [PAY_W-1:0]  in_pay;
    logic [PAY_W-1:0]  main_q, main_d;
    logic [PAY_W-1:0]  skid_q, skid_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              accept;
    logic              pop;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pay = {ctrl_in, npc_in, waddr_in, rdata2_in, alu_result_in};

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d               = 1'b0;
            skid_valid_d               = 1'b0;
            main_d[PAY_W-1 -: CTRL_W]  = '0;
            skid_d[PAY_W-1 -: CTRL_W]  = '0;
        end else if (pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
                if (accept) begin
                    skid_d       = in_pay;
                    skid_valid_d = 1'b1;
                end
            end else if (accept) begin
                main_d = in_pay;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = in_pay;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_pay;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload outputs hold their last value; only ctrl is gated into a bubble.
    assign {main_ctrl, npc_out, waddr_out, rdata2_out, alu_result_out} = main_q;
    assign out_valid = main_valid_q;
    assign ctrl_out  = main_valid_q ? main_ctrl : '0;

`ifdef EX_MEM_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (!main_valid_q && bubble_cnt_q != 16'hFFFF)
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Directed, table-driven bench for ex_mem_elastic_stage: each row is the input for one clock edge
// and the output state expected just after that edge.
module tb_ex_mem_elastic_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] alu_result_in, rdata2_in, npc_in;
    logic [15:0] alu_result_out, rdata2_out, npc_out;
    logic [3:0]  waddr_in, waddr_out;
    logic [4:0]  ctrl_in, ctrl_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_mem_elastic_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result_in  (alu_result_in),
        .rdata2_in      (rdata2_in),
        .waddr_in       (waddr_in),
        .npc_in         (npc_in),
        .ctrl_in        (ctrl_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result_out (alu_result_out),
        .rdata2_out     (rdata2_out),
        .waddr_out      (waddr_out),
        .npc_out        (npc_out),
        .ctrl_out       (ctrl_out)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [15:0] alu;
        logic [4:0]  ctrl;
        logic        e_valid;
        logic        e_ready;
        logic [15:0] e_alu;
        logic [4:0]  e_ctrl;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Other payload fields are derived from the alu value so that 0 maps to 0.
    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [15:0] alu, input logic [4:0] ctrl);
        rst           = r;
        flush         = f;
        in_valid      = iv;
        out_ready     = ordy;
        alu_result_in = alu;
        rdata2_in     = alu << 1;
        waddr_in      = alu[3:0];
        npc_in        = alu * 16'd3;
        ctrl_in       = ctrl;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic er,
                                 input logic [15:0] ealu, input logic [4:0] ectrl);
        logic [15:0] e_rd2, e_npc;
        logic [3:0]  e_wa;
        e_rd2 = ealu << 1;
        e_npc = ealu * 16'd3;
        e_wa  = ealu[3:0];
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, er});
        check({tag, ".alu"},       {16'd0, alu_result_out}, {16'd0, ealu});
        check({tag, ".ctrl"},      {27'd0, ctrl_out}, {27'd0, ectrl});
        check({tag, ".rdata2"},    {16'd0, rdata2_out}, {16'd0, e_rd2});
        check({tag, ".waddr"},     {28'd0, waddr_out}, {28'd0, e_wa});
        check({tag, ".npc"},       {16'd0, npc_out}, {16'd0, e_npc});
        $display("%s: v=%0b rdy=%0b alu=%h ctrl=%h", tag, out_valid, in_ready, alu_result_out, ctrl_out);
    endtask

    initial begin
        //            rst   flush iv    ordy  alu      ctrl    | ev    er    e_alu    e_ctrl
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h00, 5'h00,  1'b0, 1'b1, 16'h00, 5'h00}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h01, 5'h01,  1'b1, 1'b1, 16'h01, 5'h01}; // stream 1,2,3
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h02, 5'h03,  1'b1, 1'b1, 16'h02, 5'h03};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h03, 5'h05,  1'b1, 1'b1, 16'h03, 5'h05};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 5'h00,  1'b0, 1'b1, 16'h03, 5'h00}; // 2-cycle gap
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 5'h00,  1'b0, 1'b1, 16'h03, 5'h00};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h11, 5'h09,  1'b1, 1'b1, 16'h11, 5'h09}; // A -> main
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h22, 5'h11,  1'b1, 1'b0, 16'h11, 5'h09}; // B -> skid
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h33, 5'h02,  1'b1, 1'b0, 16'h11, 5'h09}; // C refused
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h33, 5'h02,  1'b1, 1'b1, 16'h22, 5'h11}; // pop A, B up
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h33, 5'h02,  1'b1, 1'b1, 16'h33, 5'h02}; // pop B, C in
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 5'h00,  1'b0, 1'b1, 16'h33, 5'h00};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h44, 5'h1F,  1'b1, 1'b1, 16'h44, 5'h1F}; // fill both
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h55, 5'h04,  1'b1, 1'b0, 16'h44, 5'h1F};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h66, 5'h01,  1'b0, 1'b1, 16'h44, 5'h00}; // flush
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 5'h00,  1'b0, 1'b1, 16'h44, 5'h00};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h77, 5'h08,  1'b1, 1'b1, 16'h77, 5'h08};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h88, 5'h04,  1'b1, 1'b0, 16'h77, 5'h08}; // skid full
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h99, 5'h04,  1'b0, 1'b1, 16'h00, 5'h00}; // reset
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 5'h00,  1'b0, 1'b1, 16'h00, 5'h00};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 5'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].alu, vecs[i].ctrl);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                          vecs[i].e_alu, vecs[i].e_ctrl);
        end

        // in_ready must not react combinationally to out_ready: main full, skid empty.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hA1, 5'h01);
        @(posedge clk); #1;
        check_outputs("seqA.load", 1'b1, 1'b1, 16'hA1, 5'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'h0);
        #1;
        check("seqA.in_ready_no_comb_path", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("seqA.in_ready_after_ordy", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check_outputs("seqA.hold", 1'b1, 1'b1, 16'hA1, 5'h01);

        // Flush coinciding with a pop and an incoming entry: everything gone next cycle.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hB2, 5'h07);
        @(posedge clk); #1;
        check_outputs("seqB.flush_pop", 1'b0, 1'b1, 16'hA1, 5'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 5'h0);
        @(posedge clk); #1;
        check_outputs("seqB.after", 1'b0, 1'b1, 16'hA1, 5'h00);

        // Back-to-back with a stall midway: order D, E, F with no loss or duplication.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hD0, 5'h01);
        @(posedge clk); #1;
        check_outputs("seqC.D", 1'b1, 1'b1, 16'hD0, 5'h01);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hE0, 5'h02);
        @(posedge clk); #1;
        check_outputs("seqC.D_stall", 1'b1, 1'b0, 16'hD0, 5'h01);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hF0, 5'h04);
        @(posedge clk); #1;
        check_outputs("seqC.E", 1'b1, 1'b1, 16'hE0, 5'h02);
        @(posedge clk); #1;
        check_outputs("seqC.F", 1'b1, 1'b1, 16'hF0, 5'h04);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 5'h0);
        @(posedge clk); #1;
        check_outputs("seqC.drain", 1'b0, 1'b1, 16'hF0, 5'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_mem_elastic_stage.md
Name: ex_mem_elastic_stage

Overview:
Parametrised EX→MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush and bubble insertion. Replaces the free-running EX/MEM latch so that MEM-side stalls (e.g. multi-cycle data memory) back-pressure EX without losing data. It sits between the ALU/forwarding logic and the data-memory and writeback stage.

Parameters:
DATA_W, 16, width of alu_result and rdata2
WADDR_W, 4, width of the register-file write address
PC_W, 16, width of npc (jal link value)
CTRL_W, 5, control vector width; bit0 WriteEn, bit1 memWrite, bit2 memRead, bit3 memToReg, bit4 jal; extra bits are carried untouched

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  kill all held and incoming entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept this cycle
alu_result_in  in  DATA_W  ALU result
rdata2_in  in  DATA_W  store data
waddr_in  in  WADDR_W  destination register
npc_in  in  PC_W  next PC for jal
ctrl_in  in  CTRL_W  control vector
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes the entry this cycle
alu_result_out  out  DATA_W  held ALU result
rdata2_out  out  DATA_W  held store data
waddr_out  out  WADDR_W  held write address
npc_out  out  PC_W  held npc
ctrl_out  out  CTRL_W  held control; forced to 0 when out_valid=0

Behaviour:
- Reset is rst, synchronous and active-high, on clock clk. Reset clears main and skid valid, all payload registers and ctrl to 0. After reset: out_valid=0, ctrl_out=0, in_ready=1.
- Storage consists of a main entry, which drives the outputs, and a skid entry. in_ready = !skid_valid. It is a registered-state decode and has no combinational path from out_ready.
- Accept: in_valid & in_ready & !flush.
- Pop: out_valid & out_ready.
- Main empty, or main popped, on accept: the new entry goes to main (latency 1 cycle, in→out). If the skid is full when main pops, the skid moves to main first and any accepted input goes to the skid.
- Main full, not popped, on accept: the input goes to the skid, and in_ready drops in the next cycle.
- Pop without accept: the skid moves to main if valid, otherwise main is cleared (valid=0).
- Simultaneous pop and accept with the skid empty: main is replaced, giving throughput of 1 per cycle.
- Order is strictly FIFO. Never overwrite a valid unpopped entry.
- Bubble: when out_valid=0, ctrl_out=0, so WriteEn, memWrite and memRead are all 0. Payload outputs hold their last value.
- Flush: next cycle, main and skid are invalid and their ctrl is cleared. Input in the flush cycle is dropped. A pop in the same cycle as flush is still a pop from the MEM viewpoint, because the MEM side samples before the edge.
- Reset mid-transfer: any held entries are discarded with no partial state.

Optional Feature:
Macro EX_MEM_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and bubble_cnt[15:0].
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid.
  - Both counters saturate at 16'hFFFF and clear on rst or flush.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1 every cycle with alu_result_in = 1, 2, 3, …, out_ready=1 → out_valid rises 1 cycle after the first accept; outputs show 1, 2, 3 on consecutive cycles; in_ready stays 1.
- Hold out_ready=0 while feeding A=0x11, B=0x22, C=0x33 → A in main, B in skid, in_ready=0 from the cycle after B; C is not accepted. Release out_ready → outputs A, B, C in order with no loss or duplication.
- Both entries full, then flush=1 for 1 cycle with in_valid=1 → next cycle out_valid=0, ctrl_out=0, in_ready=1, and the flush-cycle input never appears.
- in_valid=0 gap of 2 cycles with out_ready=1 → out_valid=0 and ctrl_out=5'b00000 for 2 cycles while alu_result_out holds its last value.
- Assert rst while the skid is full → next cycle all outputs are 0 and in_ready=1. With EX_MEM_STATS_EN: 3 stalled cycles give stall_cnt=3; after 65540 empty cycles bubble_cnt=16'hFFFF.
